paddle_ctrl: RTL and testbench

Converts the debounced up/down button levels of one player into a saturating vertical paddle position with hold-to-repeat. Sits directly downstream of the per-button debouncers: consumes their clean levels and feeds the paddle y coordinate to the pixel/collision logic. Each new press moves the paddle one step immediately. A held button keeps moving it at a fixed repeat rate after an initial delay.

---
 rtl/paddle_if.sv | 20 ++
 rtl/paddle_ctrl.sv | 125 ++++++++++++
 tb/tb_paddle_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/paddle_if.sv
// Paddle control bundle: debounced button levels in, paddle position and status out.
// slave = paddle_ctrl side, master = the button/consumer side.
interface paddle_if;
   logic       up_db;
   logic       down_db;
   logic [9:0] paddle_y;
   logic       moved;
   logic       at_top;
   logic       at_bottom;

   modport slave (
      input  up_db, down_db,
      output paddle_y, moved, at_top, at_bottom
   );

   modport master (
      output up_db, down_db,
      input  paddle_y, moved, at_top, at_bottom
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Saturating paddle position from debounced up/down levels, with optional hold-to-repeat.
// Define PADDLE_AUTOREPEAT_EN to build the IDLE/DELAY/REPEAT auto-repeat machine.
module paddle_ctrl #(
   parameter int STEP         = 4,
   parameter int Y_MIN        = 0,
   parameter int Y_MAX        = 400,
   parameter int Y_INIT       = 200,
   parameter int REPEAT_DELAY = 12500000,
   parameter int REPEAT_RATE  = 2500000
) (
   input  logic    clk,
   input  logic    reset,
   paddle_if.slave pif
);

   localparam logic [9:0] YMIN   = 10'(Y_MIN);
   localparam logic [9:0] YMAX   = 10'(Y_MAX);
   localparam logic [9:0] YINIT  = 10'(Y_INIT);
   localparam logic [9:0] STP    = 10'(STEP);
   localparam logic [9:0] UP_LIM = 10'(Y_MIN + STEP);
   localparam logic [9:0] DN_LIM = 10'(Y_MAX - STEP);

   if (Y_MIN + STEP > Y_MAX || Y_INIT < Y_MIN || Y_INIT > Y_MAX ||
       REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_cfg_err
      $error("paddle_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;

   dir_e       dir, dir_q, dir_d;
   logic       press;
   logic       do_step;
   logic [9:0] y_q, y_d, y_next;
   logic       moved_q, moved_d;

   // Compare against the limit first so the subtraction can never wrap.
   function automatic logic [9:0] step_y(input logic [9:0] y, input dir_e d);
      logic [9:0] r;
      r = y;
      if (d == DIR_UP)
         r = (y >= UP_LIM) ? (y - STP) : YMIN;
      else if (d == DIR_DOWN)
         r = (y <= DN_LIM) ? (y + STP) : YMAX;
      return r;
   endfunction

   always_comb begin
      dir = DIR_NONE;
      if (pif.up_db && !pif.down_db)
         dir = DIR_UP;
      else if (pif.down_db && !pif.up_db)
         dir = DIR_DOWN;
   end

   assign press  = (dir != DIR_NONE) && (dir != dir_q);
   assign dir_d  = dir;
   assign y_next = step_y(y_q, dir);

`ifdef PADDLE_AUTOREPEAT_EN
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW      = $clog2(CNT_MAX) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any change of direction ends a hold; a change into a new direction
   // is itself a fresh press and restarts the delay.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_step = 1'b0;
      if (state_q == S_IDLE || dir != dir_q) begin
         if (press) begin
            do_step = 1'b1;
            cnt_d   = CW'(REPEAT_DELAY);
            state_d = S_DELAY;
         end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      end else if (cnt_q == CW'(1)) begin
         do_step = 1'b1;
         cnt_d   = CW'(REPEAT_RATE);
         state_d = S_REPEAT;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign do_step = press;
`endif

   assign y_d     = do_step ? y_next : y_q;
   assign moved_d = do_step && (y_next != y_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_q     <= YINIT;
         moved_q <= 1'b0;
         dir_q   <= DIR_NONE;
      end else begin
         y_q     <= y_d;
         moved_q <= moved_d;
         dir_q   <= dir_d;
      end
   end

   assign pif.paddle_y  = y_q;
   assign pif.moved     = moved_q;
   assign pif.at_top    = (y_q == YMIN);
   assign pif.at_bottom = (y_q == YMAX);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: reset, a vector table, directed hold/overlap/reset sequences and
// random holds, all checked every cycle against a cycle-count based position model.
module tb_paddle_ctrl;
   localparam int RD = 20;
   localparam int RR = 5;
`ifdef PADDLE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   paddle_if pif();

   paddle_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk   (clk),
      .reset (rst_n),
      .pif   (pif.slave)
   );

   typedef struct {
      bit up;
      bit dn;
      int y;
      bit mv;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int pulses;
   // model: position, last direction (0 none, 1 up, 2 down), press cycle, cycle index
   int m_y, m_prev, m_t0, m_t;
   bit m_mv;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_y = 200; m_prev = 0; m_t0 = 0; m_t = 0; m_mv = 1'b0;
   endfunction

   // A press steps at once; a held direction steps again RD cycles after the
   // press and every RR cycles after that.
   function automatic void model_step(input bit u, input bit d);
      int dr, ny;
      bit st;
      dr = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
      ny = m_y;
      st = 1'b0;
      if (dr != 0 && dr != m_prev) begin
         st = 1'b1;
         m_t0 = m_t;
      end else if (AR && dr != 0 && (m_t - m_t0) >= RD && ((m_t - m_t0 - RD) % RR) == 0) begin
         st = 1'b1;
      end
      if (st) ny = (dr == 1) ? ((m_y - 4 < 0) ? 0 : m_y - 4) : ((m_y + 4 > 400) ? 400 : m_y + 4);
      m_mv = (ny != m_y);
      m_y = ny;
      m_prev = dr;
      m_t++;
   endfunction

   task automatic check_model();
      chk("paddle_y", int'(pif.paddle_y), m_y);
      chk("moved", int'(pif.moved), int'(m_mv));
      chk("at_top", int'(pif.at_top), int'(m_y == 0));
      chk("at_bottom", int'(pif.at_bottom), int'(m_y == 400));
   endtask

   task automatic cyc(input bit u, input bit d);
      pif.up_db = u;
      pif.down_db = d;
      @(posedge clk);
      #1;
      model_step(u, d);
      check_model();
      if (pif.moved) pulses++;
   endtask

   task automatic do_reset();
      pif.up_db = 1'b0;
      pif.down_db = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_y", int'(pif.paddle_y), 200);
      chk("reset_moved", int'(pif.moved), 0);
      rst_n = 1'b1;
      model_reset();
      pulses = 0;
   endtask

   vec_t vt[12];

   initial begin
      vt[0]  = '{0, 0, 200, 0};
      vt[1]  = '{1, 0, 196, 1};
      vt[2]  = '{0, 0, 196, 0};
      vt[3]  = '{0, 0, 196, 0};
      vt[4]  = '{0, 1, 200, 1};
      vt[5]  = '{1, 1, 200, 0};
      vt[6]  = '{0, 1, 204, 1};
      vt[7]  = '{1, 0, 200, 1};
      vt[8]  = '{0, 0, 200, 0};
      vt[9]  = '{1, 1, 200, 0};
      vt[10] = '{1, 0, 196, 1};
      vt[11] = '{0, 0, 196, 0};

      pif.up_db = 1'b0;
      pif.down_db = 1'b0;

      // reset and idle
      do_reset();
      repeat (10) cyc(0, 0);
      chk("idle_y", int'(pif.paddle_y), 200);
      chk("idle_top", int'(pif.at_top), 0);
      chk("idle_bottom", int'(pif.at_bottom), 0);

      // short taps, overlaps and same-cycle direction swaps
      for (int i = 0; i < 12; i++) begin
         cyc(vt[i].up, vt[i].dn);
         chk($sformatf("vec%0d_y", i), int'(pif.paddle_y), vt[i].y);
         chk($sformatf("vec%0d_moved", i), int'(pif.moved), int'(vt[i].mv));
      end

      // down held 36 cycles
      do_reset();
      repeat (36) cyc(0, 1);
      chk("hold36_pulses", pulses, AR ? 5 : 1);
      chk("hold36_y", int'(pif.paddle_y), AR ? 220 : 204);

      // down held 100 cycles
      do_reset();
      repeat (100) cyc(0, 1);
      chk("hold100_pulses", pulses, AR ? 17 : 1);
      chk("hold100_y", int'(pif.paddle_y), AR ? 268 : 204);

      // tap up into the top limit, then hold there
      do_reset();
      repeat (55) begin cyc(1, 0); cyc(0, 0); end
      chk("top_pulses", pulses, 50);
      chk("top_y", int'(pif.paddle_y), 0);
      chk("top_flag", int'(pif.at_top), 1);
      pulses = 0;
      repeat (40) cyc(1, 0);
      chk("top_hold_pulses", pulses, 0);

      // tap down into the bottom limit
      pulses = 0;
      repeat (110) begin cyc(0, 1); cyc(0, 0); end
      chk("bottom_pulses", pulses, 100);
      chk("bottom_y", int'(pif.paddle_y), 400);
      chk("bottom_flag", int'(pif.at_bottom), 1);

      // hold up, overlap down, release down
      do_reset();
      repeat (10) cyc(1, 0);
      pulses = 0;
      repeat (3) cyc(1, 1);
      chk("overlap_pulses", pulses, 0);
      cyc(1, 0);
      chk("release_y", int'(pif.paddle_y), 192);
      chk("release_moved", int'(pif.moved), 1);
      pulses = 0;
      repeat (19) cyc(1, 0);
      chk("restart_quiet", pulses, 0);
      cyc(1, 0);
      chk("restart_y", int'(pif.paddle_y), AR ? 188 : 192);

      // asynchronous reset mid-hold, button still held across deassertion
      do_reset();
      repeat (30) cyc(0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_y", int'(pif.paddle_y), 200);
      chk("async_rst_moved", int'(pif.moved), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      cyc(0, 1);
      chk("post_rst_y", int'(pif.paddle_y), 204);
      chk("post_rst_moved", int'(pif.moved), 1);

      // random holds
      do_reset();
      for (int s = 0; s < 80; s++) begin
         bit u, d;
         int len;
         u = 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 40);
         repeat (len) cyc(u, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
